// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file operation sequencer.
// The optional flag outputs are enabled by defining REGFILE_SEQ_FLAGS_EN.
package regfile_seq_pkg;

    localparam int unsigned DATA_W              = 16;
    localparam int unsigned ADDR_W              = 4;
    localparam int unsigned SHAMT_W             = 4;
    localparam int unsigned REGFILE_SEQ_LATENCY = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MOV = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // Fields of an accepted instruction still needed after the read cycle.
    typedef struct packed {
        op_e                op;
        logic [ADDR_W-1:0]  rd;
    } instr_t;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational datapath: result and carry/borrow for one sequencer opcode.
// Carry is only meaningful for ADD (sum bit DATA_W) and SUB (borrow).
module regfile_seq_alu
    import regfile_seq_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    output logic [DATA_W-1:0] result_c_o,
    output logic              carry_c_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum        = (DATA_W+1)'(op1_i) + (DATA_W+1)'(op2_i);
        result_c_o = '0;
        carry_c_o  = 1'b0;
        case (op_i)
            OP_ADD: {carry_c_o, result_c_o} = sum;
            OP_SUB: begin
                result_c_o = op1_i - op2_i;
                carry_c_o  = (op1_i < op2_i);
            end
            OP_AND:  result_c_o = op1_i & op2_i;
            OP_OR:   result_c_o = op1_i | op2_i;
            OP_XOR:  result_c_o = op1_i ^ op2_i;
            OP_SHL:  result_c_o = op1_i << op2_i[SHAMT_W-1:0];
            OP_SHR:  result_c_o = op1_i >> op2_i[SHAMT_W-1:0];
            default: result_c_o = op1_i;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one register-to-register op: IDLE -> READ -> EXEC -> WRITE.
// Define REGFILE_SEQ_FLAGS_EN to add the zero/carry flag outputs.
module regfile_op_sequencer
    import regfile_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              done
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d, raddr2_q, raddr2_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              we_q, we_d, done_q, done_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
`ifdef REGFILE_SEQ_FLAGS_EN
    logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
`else
    logic              unused_alu_carry;
    assign unused_alu_carry = alu_carry;
`endif

    regfile_seq_alu u_alu (
        .op_i       (instr_q.op),
        .op1_i      (op1_q),
        .op2_i      (op2_q),
        .result_c_o (alu_result),
        .carry_c_o  (alu_carry)
    );

    // Async reset also kills an in-flight write-back immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
`ifdef REGFILE_SEQ_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            we_q     <= we_d;
            done_q   <= done_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
`ifdef REGFILE_SEQ_FLAGS_EN
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
`ifdef REGFILE_SEQ_FLAGS_EN
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
`endif
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d.op = op_e'(instr_op);
                    instr_d.rd = instr_rd;
                    raddr1_d   = instr_rs1;
                    raddr2_d   = instr_rs2;
                    state_d    = READ;
                end
            end
            READ: begin
                op1_d   = rdata1;
                op2_d   = rdata2;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                we_d     = 1'b1;
                done_d   = 1'b1;
                waddr_d  = instr_q.rd;
                wdata_d  = alu_result;
`ifdef REGFILE_SEQ_FLAGS_EN
                flag_z_d = (alu_result == '0);
                if (instr_q.op == OP_ADD || instr_q.op == OP_SUB) begin
                    flag_c_d = alu_carry;
                end
`endif
                state_d  = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready = (state_q == IDLE) && !rst;
    assign raddr1      = raddr1_q;
    assign raddr2      = raddr2_q;
    assign we          = we_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign done        = done_q;
`ifdef REGFILE_SEQ_FLAGS_EN
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural 16x16 register file.
module tb_regfile_op_sequencer;

    localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3,
                           T_XOR = 3'd4, T_SHL = 3'd5, T_SHR = 3'd6, T_MOV = 3'd7;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
        logic        z;
        logic        c;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = '0;
    logic [3:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic [3:0]  raddr1, raddr2, waddr;
    logic [15:0] rdata1, rdata2, wdata;
    logic        we, done;
    logic        flag_z, flag_c;

    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] rf [16];
    logic [15:0] exp_rf [16];
    logic        exp_c = 1'b0;

    exp_t        sb[$];
    int          held_cyc[$];
    bit          holding = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_total = 0;

    regfile_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .done        (done)
`ifdef REGFILE_SEQ_FLAGS_EN
        ,
        .flag_z      (flag_z),
        .flag_c      (flag_c)
`endif
    );

`ifndef REGFILE_SEQ_FLAGS_EN
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    always #5 clk = ~clk;

    // Register file: combinational reads, write at the rising edge.
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we) rf[waddr] <= wdata;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            T_ADD:   return {1'b0, a} + {1'b0, b};
            T_SUB:   return {(a < b), 16'(a - b)};
            T_AND:   return {1'b0, a & b};
            T_OR:    return {1'b0, a | b};
            T_XOR:   return {1'b0, a ^ b};
            T_SHL:   return {1'b0, 16'(a << b[3:0])};
            T_SHR:   return {1'b0, 16'(a >> b[3:0])};
            default: return {1'b0, a};
        endcase
    endfunction

    // Accepts are predicted at the falling edge before the handshake edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] r;
        if (done) done_total++;
        if (we) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_we", {28'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_eq("waddr", {28'd0, waddr}, {28'd0, e.rd});
                check_eq("wdata", {16'd0, wdata}, {16'd0, e.data});
                check_eq("done_with_we", {31'd0, done}, 32'd1);
                check_eq("latency", cyc - e.cyc, 32'd3);
`ifdef REGFILE_SEQ_FLAGS_EN
                check_eq("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                check_eq("flag_c", {31'd0, flag_c}, {31'd0, e.c});
`endif
            end
        end else if (done) begin
            check_eq("done_without_we", {31'd0, done}, 32'd0);
        end
        if (instr_valid && instr_ready) begin
            r = model(instr_op, exp_rf[instr_rs1], exp_rf[instr_rs2]);
            if (instr_op == T_ADD || instr_op == T_SUB) exp_c = r[16];
            e.rd   = instr_rd;
            e.data = r[15:0];
            e.z    = (r[15:0] == 16'd0);
            e.c    = exp_c;
            e.cyc  = cyc;
            sb.push_back(e);
            exp_rf[instr_rd] = r[15:0];
            if (holding) held_cyc.push_back(cyc);
        end
    end

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        exp_rf[a] = d;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("issue_ready", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] saved14;
        logic        saved_c;
        int          done_before;
        for (int i = 0; i < 16; i++) begin
            rf[i] = 16'd0;
            exp_rf[i] = 16'd0;
        end
        // Valid held during reset must not be accepted.
        instr_valid = 1'b1; instr_op = T_ADD; instr_rd = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd0);
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_waddr", {28'd0, waddr}, 32'd0);
        check_eq("rst_wdata", {16'd0, wdata}, 32'd0);
        check_eq("rst_raddr", {24'd0, raddr1, raddr2}, 32'd0);
`ifdef REGFILE_SEQ_FLAGS_EN
        check_eq("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
`endif
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        preload(4'd1, 16'hAAAA);  preload(4'd2, 16'h5555);
        preload(4'd4, 16'hFFFF);  preload(4'd5, 16'h0001);
        preload(4'd8, 16'hF0F0);  preload(4'd9, 16'h0004);
        preload(4'd13, 16'h0001); preload(4'd14, 16'h1234);

        issue(T_ADD, 4'd3, 4'd1, 4'd2);
        issue(T_ADD, 4'd6, 4'd4, 4'd5);
        issue(T_SUB, 4'd7, 4'd5, 4'd4);
        issue(T_XOR, 4'd1, 4'd1, 4'd1);
        issue(T_SHL, 4'd10, 4'd8, 4'd9);
        issue(T_SHR, 4'd11, 4'd8, 4'd9);
        issue(T_ADD, 4'd12, 4'd10, 4'd11);
        drain();
        check_eq("r3", {16'd0, rf[3]}, 32'hFFFF);
        check_eq("r6", {16'd0, rf[6]}, 32'h0000);
        check_eq("r7", {16'd0, rf[7]}, 32'h0002);
        check_eq("r1", {16'd0, rf[1]}, 32'h0000);
        check_eq("r10", {16'd0, rf[10]}, 32'h0F00);
        check_eq("r11", {16'd0, rf[11]}, 32'h0F0F);
        check_eq("r12", {16'd0, rf[12]}, 32'h1E0F);

        // Valid held high: accepts every 4 cycles.
        done_before = done_total;
        holding = 1'b1;
        instr_valid = 1'b1; instr_op = T_ADD; instr_rd = 4'd13; instr_rs1 = 4'd13; instr_rs2 = 4'd2;
        for (int n = 0; n < 40 && held_cyc.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        holding = 1'b0;
        drain();
        check_eq("held_accepts", held_cyc.size(), 32'd3);
        if (held_cyc.size() == 3) begin
            check_eq("held_gap0", held_cyc[1] - held_cyc[0], 32'd4);
            check_eq("held_gap1", held_cyc[2] - held_cyc[1], 32'd4);
        end
        check_eq("held_dones", done_total - done_before, 32'd3);
        check_eq("r13", {16'd0, rf[13]}, 32'h0000);

        // Reset during EXEC: instruction is dropped without a write.
        saved14 = exp_rf[14];
        saved_c = exp_c;
        done_before = done_total;
        issue(T_ADD, 4'd14, 4'd1, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sb.delete();
        exp_rf[14] = saved14;
        exp_c = 1'b0;
        check_eq("midrst_we", {31'd0, we}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_ready", {31'd0, instr_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_release_ready", {31'd0, instr_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrst_no_done", done_total - done_before, 32'd0);
        check_eq("midrst_r14", {16'd0, rf[14]}, {16'd0, saved14});
        check_eq("midrst_prev_c", {31'd0, saved_c}, {31'd0, saved_c & 1'b1});

        issue(T_MOV, 4'd15, 4'd14, 4'd3);
        issue(T_OR,  4'd0,  4'd8,  4'd2);
        issue(T_AND, 4'd9,  4'd8,  4'd2);
        issue(T_SUB, 4'd2,  4'd2,  4'd13);
        drain();
        check_eq("r15", {16'd0, rf[15]}, 32'h1234);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("final_r%0d", i), {16'd0, rf[i]}, {16'd0, exp_rf[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
# regfile_op_sequencer

Instruction-driven initiator for the 16x16 register file (module `register_file_16x16`). It accepts one register-to-register operation at a time over a valid/ready handshake and reads two source registers through the register file's two read ports. It computes the result and writes it back to a destination register through the write port. It sits between an instruction source (test driver or small controller) and the register file, and owns every `we`/`waddr`/`wdata`/`raddr1`/`raddr2` signal of that file.

## Interface
- `DATA_W`, 16, register width; must match the register file.
- `ADDR_W`, 4, register address width (16 registers).
- `clk  input  1  rising-edge clock`
- `rst  input  1  asynchronous, active-high reset`
- `instr_valid  input  1  instruction present`
- `instr_ready  output  1  sequencer can accept an instruction`
- `instr_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MOV`
- `instr_rd  input  ADDR_W  destination register`
- `instr_rs1  input  ADDR_W  source register 1`
- `instr_rs2  input  ADDR_W  source register 2`
- `raddr1  output  ADDR_W  to register file read port 1`
- `raddr2  output  ADDR_W  to register file read port 2`
- `rdata1  input  DATA_W  from register file, combinational read of raddr1`
- `rdata2  input  DATA_W  from register file, combinational read of raddr2`
- `we  output  1  register file write enable`
- `waddr  output  ADDR_W  register file write address`
- `wdata  output  DATA_W  register file write data`
- `done  output  1  one-cycle pulse when a write-back is issued`
- `flag_z  output  1  result was zero (only with FLAGS_EN)`
- `flag_c  output  1  carry/borrow of the last ADD/SUB (only with FLAGS_EN)`

## Operation
- FSM states: IDLE → READ → EXEC → WRITE → IDLE. There are no other transitions apart from reset.
- IDLE:
  - `instr_ready = (state==IDLE) && !rst`.
  - A handshake (`instr_valid && instr_ready` at the rising edge) latches op, rd, rs1 and rs2, and the FSM moves to READ.
- READ:
  - `raddr1 = rs1`, `raddr2 = rs2` for the whole cycle.
  - `rdata1` and `rdata2` are captured into operand registers at the end of the cycle.
- EXEC: the result is computed from the operand registers and registered.
- WRITE:
  - `we = 1`, `waddr = rd`, `wdata = result`, `done = 1` for exactly this one cycle.
  - The register file commits the write at the closing edge.
- Arithmetic:
  - ADD and SUB wrap modulo 2^DATA_W.
  - SHL and SHR are logical shifts by `op2[3:0]`, zero-filled.
  - MOV passes `op1`; rs2 is still read but ignored.
- `rd == rs1` or `rd == rs2`: legal. Operands are captured before write-back, so the old value is used.
- Back-to-back dependent instructions need no hazard logic: the next READ is at least one cycle after the WRITE commit.
- Outside WRITE: `we = 0`, and `waddr`/`wdata` hold their last values.
- Outside READ: `raddr1`/`raddr2` hold their last values.
- `instr_*` inputs are ignored when not handshaking.

## Timing
- Handshake at edge N gives READ in cycle N+1, EXEC in N+2, WRITE (`we`/`done` high) in N+3, and IDLE again in N+4.
- Throughput is one instruction per 4 cycles; `instr_ready` is low for 3 cycles after each accept.
- Reset values: state IDLE; `we`, `done`, `flag_z`, `flag_c` = 0; `raddr1`, `raddr2`, `waddr` = 0; `wdata` = 0; operand and result registers = 0; `instr_ready` = 0 while `rst` is high.
- Reset mid-operation: `we` drops immediately (asynchronously) and no partial or late write occurs. The instruction in flight is lost and `done` is not pulsed.
- Valid asserted during reset is not accepted.
- Valid held high continuously: one accept every 4 cycles.

## Configuration
- `REGFILE_SEQ_FLAGS_EN` defined:
  - `flag_z` and `flag_c` exist and are updated at the edge that leaves EXEC.
  - `flag_z = (result == 0)` for all ops.
  - `flag_c` = bit DATA_W of the (DATA_W+1)-bit ADD sum, or borrow (`op1 < op2`) for SUB. It is unchanged for the other ops.
- Not defined: the flag ports and flag registers are absent, and the rest of the behaviour is identical.

## Structure
- Package `regfile_seq_pkg` holds:
  - the opcode enum (`OP_ADD`…`OP_MOV`, 3 bits);
  - the FSM state typedef (IDLE, READ, EXEC, WRITE);
  - `REGFILE_SEQ_LATENCY = 3`.
- Sub-module `regfile_seq_alu` is the combinational function of op, op1 and op2. It returns the result and the carry/borrow.
- The FSM, operand and result registers, and output registers live in the top.

## Test plan
Bench instantiates `regfile_op_sequencer` connected to `register_file_16x16`, with registers preloaded via the write port before the sequencer takes control.
- R1=0xAAAA, R2=0x5555, ADD rd=3 → `we` high exactly 3 cycles after accept with `waddr`=3, `wdata`=0xFFFF; R3 reads 0xFFFF; `flag_z`=0, `flag_c`=0.
- R4=0xFFFF, R5=0x0001, ADD rd=6 → `wdata`=0x0000; `flag_z`=1, `flag_c`=1 (FLAGS_EN build).
- SUB R5−R4 rd=7 → `wdata`=0x0002, `flag_c`=1 (borrow). Then XOR R1,R1 rd=1 → R1=0x0000 (rd==rs1 uses the old value).
- Preload R8=0xF0F0, R9=0x0004. SHL rd=10 → 0x0F00. SHR rd=11 → 0x0F0F. Then dependent ADD R10,R11 rd=12 issued back-to-back → 0x1E0F.
- `instr_valid` held high for 3 instructions → `instr_ready` pulses at edges 0, 4, 8; exactly 3 `done` pulses.
- Assert `rst` during EXEC → `we` and `done` never rise for that instruction, and the destination register is unchanged. After release `instr_ready`=1 and the next instruction completes normally.
